// File: rtl/boot_loader_if.sv
// Boot-loader side bus bundle: SPI EEPROM pins plus the SRAM write port and
// the ownership/status flags the top level uses to mux these buses.
//   master : the boot loader (drives SPI clock/data/select, SRAM port, flags)
//   slave  : the EEPROM/SRAM/top-level side (drives spiSDI)
interface boot_loader_if;
    logic        spiSCK;
    logic        spiSDO;
    logic        spiSDI;
    logic        spiSCS;
    logic        spiOwn;
    logic [15:0] sramAddr;
    logic [15:0] sramData;
    logic        sramWr;
    logic        sramEn;
    logic        isBooted;

    modport master (
        output spiSCK, spiSDO, spiSCS, spiOwn,
        output sramAddr, sramData, sramWr, sramEn, isBooted,
        input  spiSDI
    );

    modport slave (
        input  spiSCK, spiSDO, spiSCS, spiOwn,
        input  sramAddr, sramData, sramWr, sramEn, isBooted,
        output spiSDI
    );
endinterface

// File: rtl/boot_loader.sv
// Boot loader: after reset, reads IMG_WORDS 16-bit words from a SPI EEPROM
// (READ command 0x03, address 0x0000, SPI mode 0) and writes them to SRAM
// at consecutive addresses starting at 0. When the copy is complete it
// releases the SPI bus and raises the sticky isBooted flag.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - boot_loader_if.master: SPI pins, SRAM write port, spiOwn, isBooted
module boot_loader #(
    parameter int SCK_DIV   = 2,     // clk cycles per SCK half-period, 1..255
    parameter int IMG_WORDS = 1024   // words to copy, 1..65536
) (
    input  logic          clk,
    input  logic          rst,
    boot_loader_if.master bus
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, WRITE, DONE} state_t;

    localparam logic [8:0]  IDLE_LAST = 9'(2 * SCK_DIV - 1);
    localparam logic [8:0]  SCK_LAST  = 9'(SCK_DIV - 1);
    localparam logic [16:0] IMG_CNT   = 17'(IMG_WORDS);
    localparam logic [7:0]  CMD_READ  = 8'h03;

    state_t      state, state_nx;
    logic [8:0]  cnt;        // deselect timer in IDLE, SCK divider otherwise
    logic        sck;
    logic [3:0]  bit_cnt;
    logic [14:0] shreg;      // the 16th bit is taken straight from spiSDI
    logic [15:0] word_cnt;
    logic [16:0] remaining;  // 17 bits so 65536 words fits
    logic [15:0] sram_addr;
    logic [15:0] sram_data;
    logic        shifting;
    logic        fall;

    assign shifting = (state == CMD) || (state == ADDR) || (state == DATA);
    // Edge on which SCK goes 1->0: a bit completes, SDI is sampled.
    assign fall     = shifting && sck && (cnt == SCK_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cnt == IDLE_LAST)             state_nx = CMD;
            CMD:     if (fall && bit_cnt == 4'd7)      state_nx = ADDR;
            ADDR:    if (fall && bit_cnt == 4'd15)     state_nx = DATA;
            DATA:    if (fall && bit_cnt == 4'd15)     state_nx = WRITE;
            WRITE:   state_nx = (remaining == 17'd1) ? DONE : DATA;
            DONE:    state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: divider, bit counter, shifter, word counters, SRAM registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            sck       <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= '0;
            word_cnt  <= '0;
            remaining <= IMG_CNT;
            sram_addr <= '0;
            sram_data <= '0;
        end else if (state_nx != state) begin
            // Every state entry restarts the divider with SCK low.
            cnt     <= '0;
            sck     <= 1'b0;
            bit_cnt <= '0;
            if (state_nx == WRITE) begin
                sram_addr <= word_cnt;
                sram_data <= {shreg, bus.spiSDI};
            end
            if (state == WRITE) begin
                word_cnt  <= word_cnt + 16'd1;
                remaining <= remaining - 17'd1;
            end
        end else if (state == IDLE) begin
            cnt <= cnt + 9'd1;
        end else if (shifting) begin
            if (cnt == SCK_LAST) begin
                cnt <= '0;
                sck <= ~sck;
                if (sck) begin
                    bit_cnt <= bit_cnt + 4'd1;
                    shreg   <= {shreg[13:0], bus.spiSDI};
                end
            end else begin
                cnt <= cnt + 9'd1;
            end
        end
    end

    // Outputs
    always_comb begin
        bus.spiSCS   = 1'b1;
        bus.spiSCK   = 1'b0;
        bus.spiSDO   = 1'b0;
        bus.spiOwn   = 1'b1;
        bus.isBooted = 1'b0;
        bus.sramWr   = 1'b0;
        bus.sramEn   = 1'b0;
        case (state)
            CMD: begin
                bus.spiSCS = 1'b0;
                bus.spiSCK = sck;
                bus.spiSDO = CMD_READ[3'd7 - bit_cnt[2:0]];
            end
            ADDR, DATA: begin
                // Address is all zeros, so SDO stays low.
                bus.spiSCS = 1'b0;
                bus.spiSCK = sck;
            end
            WRITE: begin
                bus.spiSCS = 1'b0;
                bus.sramWr = 1'b1;
                bus.sramEn = 1'b1;
            end
            DONE: begin
                bus.spiOwn   = 1'b0;
                bus.isBooted = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.sramAddr = sram_addr;
    assign bus.sramData = sram_data;
endmodule
